// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one outstanding request, sub-word loads with
// sign/zero extension, sub-word stores done as read-modify-write on a
// single-ported word memory with one-cycle read latency.
module lsu_mem_port #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

  state_t            state, state_nxt;
  logic              we_q, err_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, buf_q;
  logic              accept, req_err, req_illegal, req_mis;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val, merged;

  // Address bits above ADDR_W wrap away; keep them visibly unused.
  generate
    if (ADDR_W < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^req_addr[31:ADDR_W];
    end
  endgenerate

  assign accept = req_valid && req_ready;

  // Classify the incoming request: illegal op encodings and misalignment.
  always_comb begin
    req_illegal = 1'b0;
    req_mis     = 1'b0;
    case (req_op)
      3'b000: ;
      3'b001: req_mis = req_addr[0];
      3'b010: req_mis = |req_addr[1:0];
      3'b100: req_illegal = req_we;
      3'b101: begin
        req_illegal = req_we;
        req_mis     = req_addr[0];
      end
      default: req_illegal = 1'b1;
    endcase
  end
  assign req_err = req_illegal || req_mis;

  // State register; reset aborts whatever is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: errors skip memory, word stores skip the read, others RMW.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)                     state_nxt = RESP;
        else if (req_we && req_op == 3'b010) state_nxt = WR;
        else                             state_nxt = RD;
      end
      RD:   state_nxt = RDW;
      RDW:  state_nxt = we_q ? WR : RESP;
      WR:   state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request on accept and capture the read word in RDW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      buf_q   <= 32'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        op_q    <= req_op;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
      end
      if (state == RDW) buf_q <= mem_rdata;
    end
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    ld_byte = buf_q[{addr_q[1:0], 3'b000} +: 8];
    ld_half = buf_q[{addr_q[1], 4'b0000} +: 16];
    case (op_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_val = buf_q;
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b101:  ld_val = {16'b0, ld_half};
      default: ld_val = 32'b0;
    endcase
    merged = buf_q;
    if (op_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  assign req_ready  = (state == IDLE);
  assign mem_re     = (state == RD);
  assign mem_we     = (state == WR);
  assign mem_addr   = addr_q[ADDR_W-1:2];
  assign mem_wdata  = (state != WR)     ? 32'b0 :
                      (op_q == 3'b010)  ? wdata_q : merged;
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = ((state == RESP) && !we_q && !err_q) ? ld_val : 32'b0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed vector table, hand sequences for reset
// abort and held-request behaviour, then random traffic against a model.
module tb_lsu_mem_port;
  localparam int ADDR_W = 8;
  localparam int NW     = 1 << (ADDR_W - 2);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0, req_we = 1'b0;
  logic              req_ready, resp_valid, resp_err, mem_re, mem_we;
  logic [2:0]        req_op = 3'b0;
  logic [31:0]       req_addr = 32'b0, req_wdata = 32'b0;
  logic [31:0]       resp_rdata, mem_rdata, mem_wdata;
  logic [ADDR_W-3:0] mem_addr;

  logic [31:0] sram    [NW];
  logic [31:0] ref_mem [NW];
  int tests = 0, fails = 0;

  lsu_mem_port #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Word memory: write on the edge, read data one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: results computed from the op rules with plain arithmetic.
  task automatic ref_op(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                        output int lat, output int nre, output int nwe);
    int a, widx, boff;
    logic [31:0] w, v, mask;
    a = int'(addr % 256); widx = a / 4; boff = a % 4;
    err = (op == 3) || (op >= 6) || (we && op >= 4) ||
          ((op == 1 || op == 5) && (a % 2 != 0)) || (op == 2 && boff != 0);
    rd = 0; lat = 1; nre = 0; nwe = 0;
    if (err) return;
    w = ref_mem[widx];
    if (!we) begin
      lat = 3; nre = 1;
      if (op == 2) rd = w;
      else if (op == 0 || op == 4) begin
        v = (w >> (8 * boff)) & 32'hFF;
        rd = (op == 0 && v >= 128) ? v + 32'hFFFF_FF00 : v;
      end else begin
        v = (w >> (16 * (boff / 2))) & 32'hFFFF;
        rd = (op == 1 && v >= 32768) ? v + 32'hFFFF_0000 : v;
      end
    end else if (op == 2) begin
      lat = 2; nwe = 1; ref_mem[widx] = wdata;
    end else begin
      lat = 4; nre = 1; nwe = 1;
      if (op == 0) mask = 32'hFF << (8 * boff);
      else         mask = 32'hFFFF << (16 * (boff / 2));
      ref_mem[widx] = (w & ~mask) | ((wdata << (8 * boff)) & mask);
    end
  endtask

  // Issue one request (called just after a rising edge) and observe it to
  // completion; lat counts cycles from the accept edge to resp_valid.
  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                        output int lat, output int nre, output int nwe,
                        output logic [31:0] maddr, output logic [31:0] wword, output int leak);
    bit got = 0;
    req_valid = 1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
      @(posedge clk); #1;
    end
    req_valid = 0;
    rd = 32'hDEAD_DEAD; err = 1'bx; lat = 99; nre = 0; nwe = 0; wword = 0; leak = 0; maddr = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) maddr = 32'(mem_addr);
      nre += int'(mem_re);
      nwe += int'(mem_we);
      if (mem_we) wword = mem_wdata;
      if (!mem_we && mem_wdata != 0) leak++;
      if (!resp_valid && (resp_rdata != 0 || resp_err)) leak++;
      if (resp_valid) begin
        rd = resp_rdata; err = resp_err; lat = c;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    string name; logic we; logic [2:0] op; logic [31:0] addr, wdata;
    logic [31:0] rdata; logic err; int lat, nre, nwe; logic [31:0] maddr, wword;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] rd, maddr, wword, erd;
    logic err, eerr;
    int lat, nre, nwe, leak, elat, enre, enwe;

    for (int i = 0; i < NW; i++) begin
      sram[i] = $urandom; ref_mem[i] = sram[i];
    end
    sram[0] = 32'hA5A5_0000; sram[1] = 32'h80FF_1234; sram[2] = 32'h1122_3344;
    for (int i = 0; i < 3; i++) ref_mem[i] = sram[i];

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_resp", {resp_valid, resp_err, mem_re, mem_we}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_maddr", 32'(mem_addr), 0);
    rst = 0;
    @(posedge clk); #1;

    vt = '{
      '{"lb_07",   0, 3'd0, 32'h07,  0,            32'hFFFF_FF80, 0, 3, 1, 0, 1, 0},
      '{"sh_0a",   1, 3'd1, 32'h0A,  32'hDEAD_BEEF, 0,            0, 4, 1, 1, 2, 32'hBEEF_3344},
      '{"lw_08",   0, 3'd2, 32'h08,  0,            32'hBEEF_3344, 0, 3, 1, 0, 2, 0},
      '{"sw_10",   1, 3'd2, 32'h10,  32'hCAFE_F00D, 0,            0, 2, 0, 1, 4, 32'hCAFE_F00D},
      '{"lw_mis",  0, 3'd2, 32'h06,  0,            0,            1, 1, 0, 0, 1, 0},
      '{"op7",     0, 3'd7, 32'h00,  0,            0,            1, 1, 0, 0, 0, 0},
      '{"lhu_102", 0, 3'd5, 32'h102, 0,            32'h0000_A5A5, 0, 3, 1, 0, 0, 0},
      '{"sbu_ill", 1, 3'd4, 32'h00,  32'h55,       0,            1, 1, 0, 0, 0, 0},
      '{"lh_mis",  0, 3'd1, 32'h01,  0,            0,            1, 1, 0, 0, 0, 0},
      '{"lh_07s",  0, 3'd1, 32'h06,  0,            32'hFFFF_80FF, 0, 3, 1, 0, 1, 0}
    };
    foreach (vt[k]) begin
      ref_op(vt[k].we, vt[k].op, vt[k].addr, vt[k].wdata, erd, eerr, elat, enre, enwe);
      do_req(vt[k].we, vt[k].op, vt[k].addr, vt[k].wdata, rd, err, lat, nre, nwe, maddr, wword, leak);
      chk({vt[k].name, "_rdata"}, rd, vt[k].rdata);
      chk({vt[k].name, "_err"}, 32'(err), 32'(vt[k].err));
      chk({vt[k].name, "_lat"}, lat, vt[k].lat);
      chk({vt[k].name, "_re"}, nre, vt[k].nre);
      chk({vt[k].name, "_we"}, nwe, vt[k].nwe);
      chk({vt[k].name, "_maddr"}, maddr, vt[k].maddr);
      chk({vt[k].name, "_wword"}, wword, vt[k].wword);
      chk({vt[k].name, "_leak"}, leak, 0);
    end

    // Byte store aborted by reset while in WR: no write, no response.
    req_valid = 1; req_we = 1; req_op = 3'd0; req_addr = 32'h03; req_wdata = 32'h5A;
    @(posedge clk); #1; req_valid = 0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("abort_in_wr", 32'(mem_we), 1);
    rst = 1; #1;
    chk("abort_we_drop", 32'(mem_we), 0);
    chk("abort_ready", 32'(req_ready), 1);
    @(posedge clk); @(negedge clk);
    chk("abort_no_resp", 32'(resp_valid), 0);
    rst = 0;
    @(posedge clk); #1;
    do_req(0, 3'd4, 32'h03, 0, rd, err, lat, nre, nwe, maddr, wword, leak);
    chk("abort_lbu", rd, 32'h0000_00A5);
    chk("abort_lbu_lat", lat, 3);

    // Request held through a load: not re-accepted until back in IDLE.
    req_valid = 1; req_we = 0; req_op = 3'd5; req_addr = 32'h102;
    @(posedge clk); #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold_ready_%0d", c), 32'(req_ready), 0);
      chk($sformatf("hold_resp_%0d", c), 32'(resp_valid), 32'(c == 3));
    end
    chk("hold_rdata", resp_rdata, 32'h0000_A5A5);
    @(negedge clk);
    chk("hold_idle", 32'(req_ready), 1);
    req_valid = 0;
    @(negedge clk);
    chk("hold_no_reaccept", {31'b0, req_ready}, 1);
    @(posedge clk); #1;

    // Random traffic against the reference model.
    for (int n = 0; n < 120; n++) begin
      logic rwe; logic [2:0] rop; logic [31:0] ra, rw;
      rwe = 1'($urandom_range(0, 1)); rop = 3'($urandom_range(0, 7));
      ra = $urandom_range(0, 511); rw = $urandom;
      ref_op(rwe, rop, ra, rw, erd, eerr, elat, enre, enwe);
      do_req(rwe, rop, ra, rw, rd, err, lat, nre, nwe, maddr, wword, leak);
      if (rd !== erd || err !== eerr || lat != elat || nre != enre || nwe != enwe ||
          maddr != 32'((ra % 256) / 4) || leak != 0) begin
        fails++;
        $display("FAIL rand_%0d we=%0d op=%0d a=%h: got rd=%h err=%0d lat=%0d re=%0d we=%0d ma=%0d leak=%0d expected rd=%h err=%0d lat=%0d re=%0d we=%0d",
                 n, rwe, rop, ra, rd, err, lat, nre, nwe, maddr, leak, erd, eerr, elat, enre, enwe);
      end
      tests++;
    end

    begin
      int bad = 0;
      for (int i = 0; i < NW; i++) if (sram[i] !== ref_mem[i]) bad++;
      chk("mem_contents_bad_words", bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
